// File: rtl/board_rst_pkg.sv
// Shared types and constants for the board reset sequencer.
package board_rst_pkg;

    typedef enum logic [2:0] {
        ASSERT    = 3'd0,
        WAIT_LOCK = 3'd1,
        STRETCH   = 3'd2,
        REL_SYS   = 3'd3,
        RUN       = 3'd4
    } rst_state_t;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_FPGA = 2'd1;
    localparam logic [1:0] CAUSE_MCU  = 2'd2;
    localparam logic [1:0] CAUSE_LOCK = 2'd3;

    localparam logic [7:0] RST_COUNT_MAX = 8'd255;

endpackage

// File: rtl/rst_debounce.sv
// Button synchroniser plus debounce filter; a change is accepted only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the filtered value.
module rst_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16000,
    parameter logic RELEASE_LEVEL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_db
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [15:0]            cnt;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RELEASE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= RELEASE_LEVEL;
            cnt    <= '0;
        end else if (btn_s == btn_db) begin
            cnt <= '0;
        end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= btn_s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/board_rst_seq.sv
// Board reset sequencer: debounced buttons and MMCM lock gate a staged
// release of the SoC reset followed by the peripheral reset.
module board_rst_seq
    import board_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int STRETCH_CYCLES  = 1024,
    parameter int PERIPH_LAG      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fpga_rst_btn_n,
    input  logic       mcu_rst_btn,
    input  logic       mmcm_locked,
    output logic       sys_rst_n,
    output logic       periph_rst,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count,
    output logic       seq_busy
);

    logic                   fpga_db;
    logic                   mcu_db;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    logic                   press;
    logic [1:0]             btn_cause;

    rst_state_t  state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [1:0]  cause_nxt;
    logic [7:0]  count_nxt;
    logic        enter_assert;
    logic [1:0]  assert_cause;

    rst_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RELEASE_LEVEL  (1'b1)
    ) u_fpga_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (fpga_rst_btn_n),
        .btn_db(fpga_db)
    );

    rst_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RELEASE_LEVEL  (1'b0)
    ) u_mcu_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (mcu_rst_btn),
        .btn_db(mcu_db)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], mmcm_locked};
        end
    end

    assign lock_s    = lock_sync[SYNC_STAGES-1];
    assign press     = !fpga_db || mcu_db;
    assign btn_cause = !fpga_db ? CAUSE_FPGA : CAUSE_MCU;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;
        cause_nxt    = rst_cause;
        count_nxt    = rst_count;
        enter_assert = 1'b0;
        assert_cause = btn_cause;

        case (state)
            ASSERT: begin
                if (!press) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (press)       enter_assert = 1'b1;
                else if (lock_s) state_nxt    = STRETCH;
            end
            STRETCH: begin
                if (press)                                     enter_assert = 1'b1;
                else if (!lock_s)                              state_nxt    = WAIT_LOCK;
                else if (cnt == 16'(STRETCH_CYCLES - 1))       state_nxt    = REL_SYS;
                else                                           cnt_nxt      = cnt + 16'd1;
            end
            REL_SYS, RUN: begin
                // Button cause outranks lock loss when both occur together.
                if (press) begin
                    enter_assert = 1'b1;
                end else if (!lock_s) begin
                    enter_assert = 1'b1;
                    assert_cause = CAUSE_LOCK;
                end else if (state == REL_SYS) begin
                    if (cnt == 16'(PERIPH_LAG - 1)) state_nxt = RUN;
                    else                             cnt_nxt   = cnt + 16'd1;
                end
            end
            default: state_nxt = ASSERT;
        endcase

        if (enter_assert) begin
            state_nxt = ASSERT;
            cause_nxt = assert_cause;
            if (rst_count != RST_COUNT_MAX) count_nxt = rst_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ASSERT;
            cnt        <= '0;
            rst_cause  <= CAUSE_POR;
            rst_count  <= '0;
            sys_rst_n  <= 1'b0;
            periph_rst <= 1'b1;
            seq_busy   <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rst_cause  <= cause_nxt;
            rst_count  <= count_nxt;
            sys_rst_n  <= (state_nxt == REL_SYS) || (state_nxt == RUN);
            periph_rst <= (state_nxt != RUN);
            seq_busy   <= (state_nxt != RUN);
        end
    end

endmodule

// File: tb/tb_board_rst_seq.sv
// Directed bench for board_rst_seq with small debounce/stretch/lag settings.
module tb_board_rst_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fpga_rst_btn_n;
    logic       mcu_rst_btn;
    logic       mmcm_locked;
    logic       sys_rst_n;
    logic       periph_rst;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;
    logic       seq_busy;

    int vectors     = 0;
    int miscompares = 0;

    board_rst_seq #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .STRETCH_CYCLES (8),
        .PERIPH_LAG     (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fpga_rst_btn_n(fpga_rst_btn_n),
        .mcu_rst_btn   (mcu_rst_btn),
        .mmcm_locked   (mmcm_locked),
        .sys_rst_n     (sys_rst_n),
        .periph_rst    (periph_rst),
        .rst_cause     (rst_cause),
        .rst_count     (rst_count),
        .seq_busy      (seq_busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // sel: 0 = sys_rst_n, 1 = periph_rst, 2 = seq_busy. n = edges waited, -1 on timeout.
    task automatic wait_for(input int sel, input logic val, input int limit, output int n);
        logic cur;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            cur = (sel == 0) ? sys_rst_n : (sel == 1) ? periph_rst : seq_busy;
            if (cur == val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fpga_rst_btn_n = 1'b1; mcu_rst_btn = 1'b0; mmcm_locked = 1'b1;
        tick(3);
        vectors++; if (sys_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_sys: got %b, expected 0", sys_rst_n); end
        vectors++; if (periph_rst !== 1'b1) begin miscompares++; $display("FAIL reset_periph: got %b, expected 1", periph_rst); end
        vectors++; if (rst_cause !== 2'd0) begin miscompares++; $display("FAIL reset_cause: got %0d, expected 0", rst_cause); end
        vectors++; if (rst_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", rst_count); end
        vectors++; if (seq_busy !== 1'b1) begin miscompares++; $display("FAIL reset_busy: got %b, expected 1", seq_busy); end
    endtask

    // Lock seen after 2 sync stages, then STRETCH_CYCLES+1 more: 11 edges after release.
    task automatic test_power_on;
        int n;
        rst_n = 1'b1;
        wait_for(0, 1'b1, 40, n);
        vectors++; if (n != 11) begin miscompares++; $display("FAIL por_sys_rise: got %0d cycles, expected 11", n); end
        wait_for(1, 1'b0, 20, n);
        vectors++; if (n != 3) begin miscompares++; $display("FAIL por_periph_fall: got %0d cycles, expected 3", n); end
        vectors++; if (rst_cause !== 2'd0) begin miscompares++; $display("FAIL por_cause: got %0d, expected 0", rst_cause); end
        vectors++; if (rst_count !== 8'd0) begin miscompares++; $display("FAIL por_count: got %0d, expected 0", rst_count); end
        vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL por_busy: got %b, expected 0", seq_busy); end
    endtask

    task automatic test_fpga_button;
        int n;
        fpga_rst_btn_n = 1'b0;
        wait_for(0, 1'b0, 20, n);
        vectors++; if (n != 7) begin miscompares++; $display("FAIL fpga_latency: got %0d cycles, expected 7", n); end
        vectors++; if (periph_rst !== 1'b1) begin miscompares++; $display("FAIL fpga_periph: got %b, expected 1", periph_rst); end
        vectors++; if (rst_cause !== 2'd1) begin miscompares++; $display("FAIL fpga_cause: got %0d, expected 1", rst_cause); end
        vectors++; if (rst_count !== 8'd1) begin miscompares++; $display("FAIL fpga_count: got %0d, expected 1", rst_count); end
        tick(30);
        vectors++; if (rst_count !== 8'd1 || sys_rst_n !== 1'b0) begin miscompares++; $display("FAIL fpga_held: got count %0d sys %b, expected count 1 sys 0", rst_count, sys_rst_n); end
        fpga_rst_btn_n = 1'b1;
        // Release debounce 7, WAIT_LOCK->STRETCH 1, stretch 8.
        wait_for(0, 1'b1, 40, n);
        vectors++; if (n != 16) begin miscompares++; $display("FAIL fpga_release: got %0d cycles, expected 16", n); end
        wait_for(1, 1'b0, 20, n);
        vectors++; if (n != 3) begin miscompares++; $display("FAIL fpga_periph_fall: got %0d cycles, expected 3", n); end
    endtask

    task automatic test_bounce;
        int glitch = 0;
        for (int p = 0; p < 5; p++) begin
            mcu_rst_btn = 1'b1;
            for (int c = 0; c < 3; c++) begin tick(1); if (sys_rst_n !== 1'b1) glitch++; end
            mcu_rst_btn = 1'b0;
            for (int c = 0; c < 3; c++) begin tick(1); if (sys_rst_n !== 1'b1) glitch++; end
        end
        tick(10);
        vectors++; if (glitch != 0) begin miscompares++; $display("FAIL bounce_glitch: got %0d low cycles, expected 0", glitch); end
        vectors++; if (rst_count !== 8'd1) begin miscompares++; $display("FAIL bounce_count: got %0d, expected 1", rst_count); end
        vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL bounce_busy: got %b, expected 0", seq_busy); end
    endtask

    task automatic test_lock_loss;
        int n;
        mmcm_locked = 1'b0;
        wait_for(0, 1'b0, 20, n);
        vectors++; if (n != 3) begin miscompares++; $display("FAIL lock_latency: got %0d cycles, expected 3", n); end
        vectors++; if (periph_rst !== 1'b1) begin miscompares++; $display("FAIL lock_periph: got %b, expected 1", periph_rst); end
        vectors++; if (rst_cause !== 2'd3) begin miscompares++; $display("FAIL lock_cause: got %0d, expected 3", rst_cause); end
        vectors++; if (rst_count !== 8'd2) begin miscompares++; $display("FAIL lock_count: got %0d, expected 2", rst_count); end
        tick(5);
        mmcm_locked = 1'b1;
        tick(6);
        mmcm_locked = 1'b0;   // mid-STRETCH
        tick(10);
        vectors++; if (sys_rst_n !== 1'b0 || rst_count !== 8'd2 || rst_cause !== 2'd3) begin
            miscompares++; $display("FAIL stretch_lockloss: got sys %b count %0d cause %0d, expected 0 2 3", sys_rst_n, rst_count, rst_cause);
        end
        mmcm_locked = 1'b1;
        wait_for(0, 1'b1, 40, n);
        vectors++; if (n != 11) begin miscompares++; $display("FAIL stretch_restart: got %0d cycles, expected 11", n); end
        wait_for(1, 1'b0, 20, n);
        vectors++; if (n != 3) begin miscompares++; $display("FAIL lock_periph_fall: got %0d cycles, expected 3", n); end
    endtask

    task automatic test_simultaneous;
        int n;
        fpga_rst_btn_n = 1'b0; mcu_rst_btn = 1'b1;
        wait_for(0, 1'b0, 20, n);
        vectors++; if (n != 7) begin miscompares++; $display("FAIL simul_latency: got %0d cycles, expected 7", n); end
        vectors++; if (rst_cause !== 2'd1) begin miscompares++; $display("FAIL simul_cause: got %0d, expected 1", rst_cause); end
        tick(3);
        fpga_rst_btn_n = 1'b1; mcu_rst_btn = 1'b0;
        wait_for(2, 1'b0, 60, n);
        vectors++; if (n != 19) begin miscompares++; $display("FAIL simul_rerun: got %0d cycles, expected 19", n); end
        vectors++; if (rst_count !== 8'd3) begin miscompares++; $display("FAIL simul_count: got %0d, expected 3", rst_count); end
    endtask

    task automatic test_saturation;
        int n;
        for (int i = 0; i < 260; i++) begin
            fpga_rst_btn_n = 1'b0; tick(10);
            fpga_rst_btn_n = 1'b1; tick(10);
            if (i == 250) begin
                vectors++; if (rst_count !== 8'd254) begin miscompares++; $display("FAIL sat_254: got %0d, expected 254", rst_count); end
            end
        end
        vectors++; if (rst_count !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d, expected 255", rst_count); end
        vectors++; if (rst_cause !== 2'd1) begin miscompares++; $display("FAIL sat_cause: got %0d, expected 1", rst_cause); end
        mcu_rst_btn = 1'b1; tick(10);
        vectors++; if (rst_cause !== 2'd2) begin miscompares++; $display("FAIL mcu_cause: got %0d, expected 2", rst_cause); end
        vectors++; if (rst_count !== 8'd255) begin miscompares++; $display("FAIL sat_mcu_count: got %0d, expected 255", rst_count); end
        mcu_rst_btn = 1'b0;
        wait_for(2, 1'b0, 60, n);
        vectors++; if (n != 19) begin miscompares++; $display("FAIL mcu_rerun: got %0d cycles, expected 19", n); end
    endtask

    task automatic test_async_reset;
        int n;
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (sys_rst_n !== 1'b0 || periph_rst !== 1'b1 || seq_busy !== 1'b1) begin
            miscompares++; $display("FAIL async_outputs: got sys %b periph %b busy %b, expected 0 1 1", sys_rst_n, periph_rst, seq_busy);
        end
        vectors++; if (rst_count !== 8'd0 || rst_cause !== 2'd0) begin
            miscompares++; $display("FAIL async_debug: got count %0d cause %0d, expected 0 0", rst_count, rst_cause);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_for(0, 1'b1, 40, n);
        vectors++; if (n != 11) begin miscompares++; $display("FAIL async_rerelease: got %0d cycles, expected 11", n); end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_fpga_button();
        test_bounce();
        test_lock_loss();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
